// File: rtl/rf_dump_reader.sv
// rf_dump_reader
// Debug read-out engine for the RV32I register file. A start pulse walks the
// register range FIRST_REG..LAST_REG through a dedicated read port and streams
// each {index, value} pair over a valid/ready interface. This lets a debug
// bridge dump the whole register state without using the pipeline read ports.
//
// Ports:
//   CLK          rising-edge clock
//   nRST         synchronous active-low reset
//   start_i      begin a dump (only looked at while idle)
//   abort_i      cancel a dump in progress
//   rf_addr_o    register-file read address (meaningful during FETCH)
//   rf_data_i    combinational register-file read data for rf_addr_o
//   out_valid_o  stream beat valid
//   out_ready_i  stream consumer ready
//   out_idx_o    register index of the current beat
//   out_data_o   register value of the current beat
//   out_last_o   current beat is LAST_REG
//   busy_o       engine is not idle
//   done_o       one-cycle pulse after the final beat is accepted
module rf_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  out_idx_o,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic        valid_q, valid_n;
  logic [4:0]  idx_q, idx_n;
  logic [31:0] data_q, data_n;
  logic        last_q, last_n;

  // State and beat registers. The beat is a snapshot taken in FETCH, so later
  // register-file writes to the same index cannot disturb a held beat.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      valid_q <= 1'b0;
      idx_q   <= 5'd0;
      data_q  <= 32'd0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      valid_q <= valid_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      last_q  <= last_n;
    end
  end

  // Next-state logic. Abort takes priority over a simultaneous handshake.
  // The counter only advances on a non-last handshake, and the last beat is
  // exactly the one whose index equals LAST_IDX, so it never passes LAST_REG.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = valid_q;
    idx_n   = idx_q;
    data_n  = data_q;
    last_n  = last_q;
    case (state)
      IDLE: begin
        if (start_i) begin
          cnt_n   = FIRST_IDX;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (abort_i) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          state_n = IDLE;
        end else begin
          data_n  = rf_data_i;
          idx_n   = cnt;
          last_n  = (cnt == LAST_IDX);
          valid_n = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (abort_i) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          state_n = IDLE;
        end else if (valid_q && out_ready_i) begin
          valid_n = 1'b0;
          if (last_q) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt + 5'd1;
            state_n = FETCH;
          end
        end
      end
      DONE: begin
        if (abort_i) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // The read address is simply the walk counter; it holds outside FETCH.
  assign rf_addr_o   = cnt;
  assign out_valid_o = valid_q;
  assign out_idx_o   = idx_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader
// Bench for rf_dump_reader. Two instances share a register-file model: one
// dumps the full range 0..31, the other the narrow range 10..12. The narrow
// instance is driven from a cycle-by-cycle vector table; the full instance is
// driven by dump runs checked against a scoreboard of expected beats built
// from the register-file contents when each dump starts.
module tb_rf_dump_reader;

  logic        clk;
  logic        nrst;
  logic        start0, start1, abort, ready;

  logic [4:0]  a_addr, a_idx, b_addr, b_idx;
  logic [31:0] a_rdata, a_data, b_rdata, b_data;
  logic        a_valid, a_last, a_busy, a_done;
  logic        b_valid, b_last, b_busy, b_done;

  logic [31:0] rf [32];
  logic [37:0] expq [$];
  logic [31:0] seen5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        nrst, start, abort, ready;
    logic        busy, done, valid, last;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        chkBeat, chkAddr;
  } vec_t;

  vec_t vq [$];

  // Register file read port: x0 always reads as zero.
  assign a_rdata = (a_addr == 5'd0) ? 32'd0 : rf[a_addr];
  assign b_rdata = (b_addr == 5'd0) ? 32'd0 : rf[b_addr];

  rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dutFull (
    .CLK(clk), .nRST(nrst), .start_i(start0), .abort_i(abort),
    .rf_addr_o(a_addr), .rf_data_i(a_rdata),
    .out_valid_o(a_valid), .out_ready_i(ready), .out_idx_o(a_idx),
    .out_data_o(a_data), .out_last_o(a_last), .busy_o(a_busy), .done_o(a_done)
  );

  rf_dump_reader #(.FIRST_REG(10), .LAST_REG(12)) dutNarrow (
    .CLK(clk), .nRST(nrst), .start_i(start1), .abort_i(abort),
    .rf_addr_o(b_addr), .rf_data_i(b_rdata),
    .out_valid_o(b_valid), .out_ready_i(ready), .out_idx_o(b_idx),
    .out_data_o(b_data), .out_last_o(b_last), .busy_o(b_busy), .done_o(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (bound expired)", name);
  endtask

  task automatic addVec(input logic n, s, ab, r, bu, dn, v, l,
                        input logic [4:0] i, input logic [31:0] d, input logic [4:0] ad,
                        input logic cb, ca);
    vec_t t;
    t.nrst = n; t.start = s; t.abort = ab; t.ready = r;
    t.busy = bu; t.done = dn; t.valid = v; t.last = l;
    t.idx = i; t.data = d; t.addr = ad; t.chkBeat = cb; t.chkAddr = ca;
    vq.push_back(t);
  endtask

  // One table row: drive at the falling edge, let one rising edge pass, then
  // compare the narrow instance's outputs shortly after that edge.
  task automatic applyStimulus(input vec_t v, input int row);
    logic [45:0] act, exp;
    @(negedge clk);
    nrst = v.nrst; start1 = v.start; abort = v.abort; ready = v.ready;
    @(posedge clk);
    #1;
    act = {b_busy, b_done, b_valid,
           v.chkBeat ? b_last : 1'b0, v.chkBeat ? b_idx : 5'd0,
           v.chkBeat ? b_data : 32'd0, v.chkAddr ? b_addr : 5'd0};
    exp = {v.busy, v.done, v.valid,
           v.chkBeat ? v.last : 1'b0, v.chkBeat ? v.idx : 5'd0,
           v.chkBeat ? v.data : 32'd0, v.chkAddr ? v.addr : 5'd0};
    checkOutput($sformatf("table row %0d", row), 64'(act), 64'(exp));
  endtask

  // One dump on the full-range instance.
  // mode 0: ready always high; 1: backpressure on idx 3 and a write to x5
  // while its beat is held; 2: random ready and random start pulses while
  // busy; 3: abort while the idx 7 beat is valid.
  task automatic runDump(input int mode);
    logic [37:0] exp;
    logic [37:0] prevBeat;
    bit prevStall, finished, wrote, aborted;
    int cyc, doneCnt, doneAt, firstAt, bpLeft, idx3Cnt, postAbort;
    prevStall = 0; finished = 0; wrote = 0; aborted = 0;
    cyc = 0; doneCnt = 0; doneAt = -1; firstAt = -1; bpLeft = 5; idx3Cnt = 0; postAbort = 0;
    prevBeat = '0;
    expq.delete();
    for (int k = 0; k < 32; k++)
      expq.push_back({(k == 31), 5'(k), (k == 0) ? 32'd0 : rf[k]});
    @(negedge clk);
    start0 = 1'b1; abort = 1'b0; ready = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (!finished && cyc < 1000) begin
      abort = 1'b0;
      start0 = 1'b0;
      ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (aborted) begin
        if (postAbort == 0)
          checkOutput("abort outputs {valid,last,busy,done}",
                      64'({a_valid, a_last, a_busy, a_done}), 64'd0);
        if (a_done) doneCnt++;
        postAbort++;
        if (postAbort == 5) finished = 1;
      end else begin
        if (mode == 2 && a_busy) start0 = ($urandom_range(0, 3) == 0);
        if (mode == 1 && a_valid && a_idx == 5'd3 && bpLeft > 0) begin
          ready = 1'b0;
          bpLeft--;
        end
        if (mode == 1 && a_valid && a_idx == 5'd5 && !wrote) begin
          rf[5] = 32'hDEADBEEF;
          wrote = 1;
          ready = 1'b0;
        end
        if (mode == 3 && a_valid && a_idx == 5'd7) begin
          abort = 1'b1;
          ready = 1'b0;
          aborted = 1;
        end
        if (prevStall)
          checkOutput("held beat {valid,last,idx,data}",
                      64'({a_valid, a_last, a_idx, a_data}), 64'({1'b1, prevBeat}));
        if (a_valid && firstAt < 0) firstAt = cyc;
        if (a_valid && a_idx == 5'd3) idx3Cnt++;
        if (a_valid && ready && !abort) begin
          if (expq.size() == 0) begin
            failNow("unexpected extra beat");
          end else begin
            exp = expq.pop_front();
            checkOutput("beat {last,idx,data}", 64'({a_last, a_idx, a_data}), 64'(exp));
          end
          if (a_idx == 5'd5) seen5 = a_data;
        end
        prevStall = a_valid && !ready && !abort;
        prevBeat = {a_last, a_idx, a_data};
        if (a_done) begin
          doneCnt++;
          doneAt = cyc;
        end
        if (doneCnt > 0 && !a_busy) finished = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start0 = 1'b0; abort = 1'b0; ready = 1'b1;
    if (!finished) failNow($sformatf("dump mode %0d did not finish", mode));
    if (mode != 3) begin
      checkOutput("done pulse count", 64'(doneCnt), 64'd1);
      checkOutput("beats not delivered", 64'(expq.size()), 64'd0);
    end else begin
      checkOutput("done pulses after abort", 64'(doneCnt), 64'd0);
    end
    if (mode == 0) begin
      checkOutput("first beat cycle", 64'(firstAt), 64'd1);
      checkOutput("done cycle", 64'(doneAt), 64'd64);
    end
    if (mode == 1) checkOutput("idx3 valid cycles", 64'(idx3Cnt), 64'd6);
  endtask

  // Reset in the middle of a dump, while the idx 9 beat is valid.
  task automatic resetMidDump();
    bit found;
    found = 0;
    @(negedge clk);
    start0 = 1'b1; ready = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (a_valid && a_idx == 5'd9) found = 1;
      else @(negedge clk);
    end
    if (!found) failNow("idx 9 beat never appeared");
    nrst = 1'b0; ready = 1'b0;
    @(negedge clk);
    checkOutput("reset mid-dump outputs",
                64'({a_busy, a_done, a_valid, a_last, a_idx, a_data, a_addr}), 64'd0);
    nrst = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset busy", 64'(a_busy), 64'd0);
  endtask

  initial begin
    nrst = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; ready = 1'b0;
    seen5 = 32'd0;
    rf[0] = 32'd0;
    for (int k = 1; k < 32; k++) rf[k] = 32'h100 + 32'(k);

    // nrst start abort ready | busy done valid last idx data addr | chkBeat chkAddr
    addVec(0, 0, 0, 1,  0, 0, 0, 0, 5'd0,  32'h0,   5'd0,  1, 1);
    addVec(1, 1, 0, 0,  1, 0, 0, 0, 5'd0,  32'h0,   5'd10, 0, 1);
    addVec(1, 0, 0, 0,  1, 0, 1, 0, 5'd10, 32'h10A, 5'd0,  1, 0);
    addVec(1, 1, 0, 0,  1, 0, 1, 0, 5'd10, 32'h10A, 5'd0,  1, 0);
    addVec(1, 0, 0, 1,  1, 0, 0, 0, 5'd0,  32'h0,   5'd11, 0, 1);
    addVec(1, 0, 0, 1,  1, 0, 1, 0, 5'd11, 32'h10B, 5'd0,  1, 0);
    addVec(1, 0, 0, 1,  1, 0, 0, 0, 5'd0,  32'h0,   5'd12, 0, 1);
    addVec(1, 0, 0, 1,  1, 0, 1, 1, 5'd12, 32'h10C, 5'd0,  1, 0);
    addVec(1, 0, 0, 1,  1, 1, 0, 0, 5'd0,  32'h0,   5'd0,  0, 0);
    addVec(1, 0, 0, 1,  0, 0, 0, 0, 5'd0,  32'h0,   5'd0,  0, 0);
    addVec(1, 1, 1, 0,  1, 0, 0, 0, 5'd0,  32'h0,   5'd10, 0, 1);
    addVec(1, 0, 1, 0,  0, 0, 0, 0, 5'd0,  32'h0,   5'd0,  0, 0);
    addVec(1, 1, 0, 0,  1, 0, 0, 0, 5'd0,  32'h0,   5'd10, 0, 1);
    addVec(1, 0, 0, 0,  1, 0, 1, 0, 5'd10, 32'h10A, 5'd0,  1, 0);
    addVec(1, 0, 1, 1,  0, 0, 0, 0, 5'd0,  32'h0,   5'd0,  0, 0);
    addVec(1, 1, 0, 0,  1, 0, 0, 0, 5'd0,  32'h0,   5'd10, 0, 1);
    addVec(1, 0, 0, 0,  1, 0, 1, 0, 5'd10, 32'h10A, 5'd0,  1, 0);
    addVec(0, 0, 0, 0,  0, 0, 0, 0, 5'd0,  32'h0,   5'd0,  1, 1);

    $display("[TB] narrow-range vector table");
    for (int i = 0; i < vq.size(); i++) applyStimulus(vq[i], i);
    @(negedge clk);
    nrst = 1'b1; start1 = 1'b0; abort = 1'b0; ready = 1'b1;

    $display("[TB] full dump");
    runDump(0);
    $display("[TB] backpressure and snapshot");
    runDump(1);
    checkOutput("x5 held beat keeps old value", 64'(seen5), 64'h105);
    runDump(0);
    checkOutput("x5 second dump sees new value", 64'(seen5), 64'hDEADBEEF);
    $display("[TB] abort on idx 7 then restart");
    runDump(3);
    runDump(0);
    $display("[TB] random ready with start while busy");
    for (int r = 0; r < 3; r++) runDump(2);
    $display("[TB] reset mid-dump");
    resetMidDump();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
